// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution kernel sequencer family.
package conv_pkg;

  localparam int unsigned NTAPS          = 9;
  localparam int unsigned DEF_BLUR_SHIFT = 5;
  localparam logic [3:0]  LAST_TAP       = 4'(NTAPS - 1);

  typedef enum logic [1:0] {
    SEL_BLUR  = 2'd0,
    SEL_EDGE  = 2'd1,
    SEL_SHARP = 2'd2,
    SEL_PASS  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/conv_kernel_seq_if.sv
// Window-in / pixel-out handshakes plus the shared kernel ROM port.
interface conv_kernel_seq_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned KER_W = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [9*PIX_W-1:0]      in_win;
  logic [1:0]              in_sel;
  logic [3:0]              ker_addr;
  logic signed [KER_W-1:0] ker1_dout;
  logic signed [KER_W-1:0] ker2_dout;
  logic signed [KER_W-1:0] ker3_dout;
  logic                    out_valid;
  logic                    out_ready;
  logic [PIX_W-1:0]        out_pixel;

  modport slave (
    input  in_valid, in_win, in_sel, ker1_dout, ker2_dout, ker3_dout, out_ready,
    output in_ready, ker_addr, out_valid, out_pixel
  );

  modport master (
    output in_valid, in_win, in_sel, ker1_dout, ker2_dout, ker3_dout, out_ready,
    input  in_ready, ker_addr, out_valid, out_pixel
  );

endinterface

// File: rtl/conv_sat.sv
// Normalise a signed accumulator (optional arithmetic shift) and clamp it to an unsigned pixel.
module conv_sat #(
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BLUR_SHIFT = 5
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    shift_en,
  output logic [PIX_W-1:0]        pix
);

  localparam logic signed [ACC_W-1:0] PixMax = ACC_W'((1 << PIX_W) - 1);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = shift_en ? (acc >>> BLUR_SHIFT) : acc;
    if (shifted[ACC_W-1]) begin
      pix = '0;
    end else if (shifted > PixMax) begin
      pix = '1;
    end else begin
      pix = shifted[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/conv_kernel_seq.sv
// One 3x3 convolution per transaction: walks the kernel ROM address 0..8, MACs each tap
// against its latched pixel, then presents the normalised, saturated result until taken.
module conv_kernel_seq
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned KER_W      = 5,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned BLUR_SHIFT = DEF_BLUR_SHIFT
) (
  input logic              clk,
  input logic              rst,
  conv_kernel_seq_if.slave bus
);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    vld_q;
  logic [3:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PIX_W-1:0]        pix_q [NTAPS];
  sel_e                    sel_q;

  logic                        issue;
  logic                        accept;
  logic signed [KER_W-1:0]     tap;
  logic [PIX_W-1:0]            pix_cur;
  logic signed [KER_W+PIX_W:0] prod;
  logic [PIX_W-1:0]            sat_pix;

  // Address phase runs while the counter is inside 0..8; the ROM answers one cycle later.
  assign issue  = (state_q == StRun) && (cnt_q <= LAST_TAP);
  assign accept = (state_q == StIdle) && bus.in_valid;
  assign idx_d  = issue ? cnt_q : '0;

  always_comb begin
    unique case (sel_q)
      SEL_BLUR:  tap = bus.ker1_dout;
      SEL_EDGE:  tap = bus.ker2_dout;
      SEL_SHARP: tap = bus.ker3_dout;
      SEL_PASS:  tap = '0;
    endcase
  end

  assign pix_cur = pix_q[idx_q];
  assign prod    = tap * $signed({1'b0, pix_cur});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StRun;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StRun: begin
        if (issue) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (vld_q) begin
          acc_d = acc_q + ACC_W'(prod);
          if (idx_q == LAST_TAP) begin
            state_d = StOut;
            cnt_d   = '0;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= issue;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_BLUR;
      for (int i = 0; i < NTAPS; i++) begin
        pix_q[i] <= '0;
      end
    end else if (accept) begin
      sel_q <= sel_e'(bus.in_sel);
      for (int i = 0; i < NTAPS; i++) begin
        pix_q[i] <= bus.in_win[PIX_W*i +: PIX_W];
      end
    end
  end

  conv_sat #(
    .ACC_W      (ACC_W),
    .PIX_W      (PIX_W),
    .BLUR_SHIFT (BLUR_SHIFT)
  ) u_sat (
    .acc      (acc_q),
    .shift_en (sel_q == SEL_BLUR),
    .pix      (sat_pix)
  );

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.ker_addr  = issue ? cnt_q : '0;
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_pixel = (state_q != StOut) ? '0 :
                         (sel_q == SEL_PASS) ? pix_q[4] : sat_pix;

endmodule

// File: tb/tb_conv_kernel_seq.sv
// Directed bench for conv_kernel_seq with behavioural kernel ROMs (registered read).
module tb_conv_kernel_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  conv_kernel_seq_if #(.PIX_W(8), .KER_W(5)) bus ();

  conv_kernel_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [4:0] rom1 [9] = '{5'sd2, 5'sd4, 5'sd2, 5'sd4, 5'sd8, 5'sd4, 5'sd2, 5'sd4, 5'sd2};
  logic signed [4:0] rom2 [9] = '{5'sd0, 5'sd1, 5'sd0, 5'sd1, -5'sd4, 5'sd1, 5'sd0, 5'sd1, 5'sd0};
  logic signed [4:0] rom3 [9] = '{5'sd0, -5'sd1, 5'sd0, -5'sd1, 5'sd5, -5'sd1, 5'sd0, -5'sd1,
                                  5'sd0};

  always @(posedge clk) begin
    bus.ker1_dout <= rom1[bus.ker_addr];
    bus.ker2_dout <= rom2[bus.ker_addr];
    bus.ker3_dout <= rom3[bus.ker_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input string tag, input logic [1:0] sel, input logic [71:0] win,
                         input int exp_pix, input bit chk_addr, input bit pulse_busy);
    int n;
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_win   = win;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      if (chk_addr) check({tag, "_addr"}, int'(bus.ker_addr), (n <= 8) ? n : 0);
      if (pulse_busy && n == 3) begin
        check({tag, "_busy_ready"}, int'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_win   = {9{8'hff}};
      end
      if (pulse_busy && n == 4) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 10);
    check({tag, "_pixel"}, int'(bus.out_pixel), exp_pix);
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_drop_valid"}, int'(bus.out_valid), 0);
    end
  endtask

  initial begin
    int          k;
    logic [7:0]  held;
    logic [71:0] rwin;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_win    = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_ker_addr", int'(bus.ker_addr), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_pixel", int'(bus.out_pixel), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_txn("blur100", 2'd0, {9{8'd100}}, 100, 1'b1, 1'b0);
    run_txn("blur255", 2'd0, {9{8'd255}}, 255, 1'b0, 1'b0);
    run_txn("edge240", 2'd1, pack9(0, 60, 0, 60, 0, 60, 0, 60, 0), 240, 1'b0, 1'b0);
    run_txn("edge_neg", 2'd1, pack9(0, 0, 0, 0, 255, 0, 0, 0, 0), 0, 1'b0, 1'b0);
    run_txn("sharp_sat", 2'd2, pack9(10, 10, 10, 10, 200, 10, 10, 10, 10), 255, 1'b0, 1'b0);
    run_txn("sharp140", 2'd2, pack9(90, 90, 90, 90, 100, 90, 90, 90, 90), 140, 1'b0, 1'b0);

    // Backpressure with a stray in_valid during RUN; blur of lone 50 -> 400 >>> 5 = 12.
    bus.out_ready = 1'b0;
    run_txn("bp", 2'd0, pack9(0, 0, 0, 0, 50, 0, 0, 0, 0), 12, 1'b0, 1'b1);
    held = bus.out_pixel;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_pixel", int'(bus.out_pixel), int'(held));
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_ready", int'(bus.in_ready), 1);
    run_txn("after_bp", 2'd2, pack9(90, 90, 90, 90, 100, 90, 90, 90, 90), 140, 1'b0, 1'b0);

    // Abort mid-RUN with reset.
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_win   = {9{8'd100}};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (bus.ker_addr != 4'd4 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_reached_addr4", int'(bus.ker_addr), 4);
    rst = 1'b1;
    #1;
    check("abort_ker_addr", int'(bus.ker_addr), 0);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_release_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_output", int'(bus.out_valid), 0);
    end
    run_txn("post_abort", 2'd0, {9{8'd100}}, 100, 1'b0, 1'b0);

    // Pass-through: centre pixel fixed, the rest random.
    for (int i = 0; i < 9; i++) rwin[8*i +: 8] = 8'($urandom_range(0, 255));
    rwin[39:32] = 8'd77;
    run_txn("pass77", 2'd3, rwin, 77, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
